// File: rtl/video_out_stage_if.sv
// Show-ahead pixel stream between the framebuffer reader (master) and the
// pixel-clock output stage (slave).
interface video_out_stage_if;
  logic        stream_ena_o;
  logic [15:0] stream_data_i;
  logic        stream_err_underflow_i;

  modport master (
    input  stream_ena_o,
    output stream_data_i,
    output stream_err_underflow_i
  );

  modport slave (
    output stream_ena_o,
    input  stream_data_i,
    input  stream_err_underflow_i
  );
endinterface

// File: rtl/video_out_stage.sv
// Pixel-clock output stage: places the framebuffer window inside the active
// area (optional 2x replication), decodes RGB444/565, fills a border colour.
module video_out_stage #(
  parameter int unsigned FB_WIDTH  = 640,
  parameter int unsigned FB_HEIGHT = 480,
  parameter int unsigned H_OFFSET  = 0,
  parameter int unsigned V_OFFSET  = 0,
  parameter int unsigned SCALE     = 1
) (
  input  logic             clk_pix,
  input  logic             reset_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic             de_i,
  input  logic             frame_i,
  input  logic             line_i,
  input  logic             fmt_i,
  input  logic [23:0]      border_rgb_i,
  video_out_stage_if.slave stream,
  output logic [7:0]       red_o,
  output logic [7:0]       green_o,
  output logic [7:0]       blue_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic             underflow_o,
  output logic [15:0]      underflow_count_o
);

  if (SCALE != 1 && SCALE != 2) begin : g_bad_scale
    $error("video_out_stage: SCALE must be 1 or 2");
  end

  localparam logic [11:0] H_OFF  = 12'(H_OFFSET);
  localparam logic [11:0] V_OFF  = 12'(V_OFFSET);
  localparam logic [11:0] H_LEN  = 12'(FB_WIDTH * SCALE);
  localparam logic [11:0] V_LEN  = 12'(FB_HEIGHT * SCALE);
  localparam int unsigned LB_AW  = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam bit          SCALE2 = (SCALE == 2);

  typedef enum logic [1:0] {
    SRC_BLANK  = 2'd0,
    SRC_BORDER = 2'd1,
    SRC_WIN    = 2'd2
  } src_e;

  logic [11:0] col_q, col_d, row_q, row_d;
  logic        de_prev_q, de_prev_d;
  logic        armed_q, armed_d;
  logic        ufl_q, ufl_d;
  logic [15:0] ufl_cnt_q, ufl_cnt_d;

  logic [11:0] wx, wy;
  logic        in_win, ena;

  src_e        s1_src_q, s1_src_d;
  logic        s1_lb_q, s1_lb_d;
  logic [15:0] s1_pix_q, s1_pix_d;
  logic        s1_err_q, s1_err_d;
  logic        s1_fmt_q, s1_fmt_d;
  logic [23:0] s1_border_q, s1_border_d;
  logic        s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_de_q, s1_de_d;
  logic [16:0] lb_rd_q;

  logic [15:0] word;
  logic        word_err;
  logic [23:0] dec_rgb;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;

  // Unsigned wrap makes one compare per axis cover both window edges,
  // since offset + length never exceeds the 12-bit range.
  always_comb begin
    wx     = col_q - H_OFF;
    wy     = row_q - V_OFF;
    in_win = de_i && (wx < H_LEN) && (wy < V_LEN);
    ena    = armed_q && in_win && (!SCALE2 || (!wx[0] && !wy[0]));
  end

  assign stream.stream_ena_o = ena;

  always_comb begin
    col_d = col_q;
    if (line_i)    col_d = '0;
    else if (de_i) col_d = col_q + 12'd1;

    row_d = row_q;
    if (frame_i)                   row_d = '0;
    else if (de_prev_q && !de_i)   row_d = row_q + 12'd1;

    de_prev_d = de_i;
    armed_d   = armed_q | frame_i;

    ufl_d     = ufl_q;
    ufl_cnt_d = ufl_cnt_q;
    if (frame_i) ufl_d = 1'b0;
    if (ena && stream.stream_err_underflow_i) begin
      ufl_d = 1'b1;
      if (ufl_cnt_q != '1) ufl_cnt_d = ufl_cnt_q + 16'd1;
    end
  end

  // Stage 1: capture the fetched word (held across the horizontal repeat)
  // and decide where the pixel comes from.
  always_comb begin
    s1_src_d = SRC_BLANK;
    if (de_i) s1_src_d = (in_win && armed_q) ? SRC_WIN : SRC_BORDER;
    s1_lb_d     = SCALE2 && wy[0];
    s1_pix_d    = ena ? stream.stream_data_i : s1_pix_q;
    s1_err_d    = ena ? stream.stream_err_underflow_i : s1_err_q;
    s1_fmt_d    = fmt_i;
    s1_border_d = border_rgb_i;
    s1_hs_d     = hsync_i;
    s1_vs_d     = vsync_i;
    s1_de_d     = de_i;
  end

  if (SCALE == 2) begin : g_lbuf
    logic [16:0]      lb_mem [FB_WIDTH];
    logic [LB_AW-1:0] lb_addr;
    assign lb_addr = wx[LB_AW:1];
    always_ff @(posedge clk_pix) begin
      if (ena) lb_mem[lb_addr] <= {stream.stream_err_underflow_i, stream.stream_data_i};
      lb_rd_q <= lb_mem[lb_addr];
    end
  end else begin : g_no_lbuf
    assign lb_rd_q = '0;
  end

  // Stage 2: decode and final source select.
  always_comb begin
    word     = s1_lb_q ? lb_rd_q[15:0] : s1_pix_q;
    word_err = s1_lb_q ? lb_rd_q[16]   : s1_err_q;
    if (s1_fmt_q)
      dec_rgb = {word[15:11], word[15:13], word[10:5], word[10:9], word[4:0], word[4:2]};
    else
      dec_rgb = {word[11:8], word[11:8], word[7:4], word[7:4], word[3:0], word[3:0]};

    rgb_d = '0;
    case (s1_src_q)
      SRC_BORDER: rgb_d = s1_border_q;
      SRC_WIN:    rgb_d = word_err ? 24'hFF0000 : dec_rgb;
      default:    rgb_d = '0;
    endcase
    hs_d = s1_hs_q;
    vs_d = s1_vs_q;
    de_d = s1_de_q;
  end

  always_ff @(posedge clk_pix or posedge reset_i) begin
    if (reset_i) begin
      col_q       <= '0;
      row_q       <= '0;
      de_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
      ufl_q       <= 1'b0;
      ufl_cnt_q   <= '0;
      s1_src_q    <= SRC_BLANK;
      s1_lb_q     <= 1'b0;
      s1_pix_q    <= '0;
      s1_err_q    <= 1'b0;
      s1_fmt_q    <= 1'b0;
      s1_border_q <= '0;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
      s1_de_q     <= 1'b0;
      rgb_q       <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      de_prev_q   <= de_prev_d;
      armed_q     <= armed_d;
      ufl_q       <= ufl_d;
      ufl_cnt_q   <= ufl_cnt_d;
      s1_src_q    <= s1_src_d;
      s1_lb_q     <= s1_lb_d;
      s1_pix_q    <= s1_pix_d;
      s1_err_q    <= s1_err_d;
      s1_fmt_q    <= s1_fmt_d;
      s1_border_q <= s1_border_d;
      s1_hs_q     <= s1_hs_d;
      s1_vs_q     <= s1_vs_d;
      s1_de_q     <= s1_de_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      de_q        <= de_d;
    end
  end

  assign red_o             = rgb_q[23:16];
  assign green_o           = rgb_q[15:8];
  assign blue_o            = rgb_q[7:0];
  assign hsync_o           = hs_q;
  assign vsync_o           = vs_q;
  assign de_o              = de_q;
  assign underflow_o       = ufl_q;
  assign underflow_count_o = ufl_cnt_q;

endmodule

// File: tb/tb_video_out_stage.sv
// Scoreboard bench: three placements of the output stage share one small
// timing generator; expected outputs are queued per cycle and popped 2 later.
module tb_video_out_stage;
  localparam int HT = 40, HA = 32, VT = 24, VA = 20;
  localparam int NI = 3;
  localparam int FW [NI] = '{32, 16, 16};
  localparam int FH [NI] = '{20, 10, 10};
  localparam int HO [NI] = '{0, 8, 0};
  localparam int VO [NI] = '{0, 4, 0};
  localparam int SC [NI] = '{1, 1, 2};
  localparam logic [23:0] BRD [NI] = '{24'h123456, 24'h202020, 24'h0A0B0C};

  logic clk_pix = 1'b0;
  logic reset_i, hsync_i, vsync_i, de_i, frame_i, line_i, fmt_i;
  logic [15:0] sdat [NI];
  logic        serr [NI];
  logic        ena  [NI];
  logic [7:0]  r [NI], g [NI], b [NI];
  logic        hs [NI], vs [NI], de [NI], ufl [NI];
  logic [15:0] ucnt [NI];

  video_out_stage_if if0 ();
  video_out_stage_if if1 ();
  video_out_stage_if if2 ();

  assign if0.stream_data_i = sdat[0];
  assign if1.stream_data_i = sdat[1];
  assign if2.stream_data_i = sdat[2];
  assign if0.stream_err_underflow_i = serr[0];
  assign if1.stream_err_underflow_i = serr[1];
  assign if2.stream_err_underflow_i = serr[2];
  assign ena[0] = if0.stream_ena_o;
  assign ena[1] = if1.stream_ena_o;
  assign ena[2] = if2.stream_ena_o;

  video_out_stage #(.FB_WIDTH(32), .FB_HEIGHT(20), .H_OFFSET(0), .V_OFFSET(0), .SCALE(1)) u0 (
    .clk_pix(clk_pix), .reset_i(reset_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .de_i(de_i), .frame_i(frame_i), .line_i(line_i), .fmt_i(fmt_i),
    .border_rgb_i(24'h123456), .stream(if0),
    .red_o(r[0]), .green_o(g[0]), .blue_o(b[0]),
    .hsync_o(hs[0]), .vsync_o(vs[0]), .de_o(de[0]),
    .underflow_o(ufl[0]), .underflow_count_o(ucnt[0]));

  video_out_stage #(.FB_WIDTH(16), .FB_HEIGHT(10), .H_OFFSET(8), .V_OFFSET(4), .SCALE(1)) u1 (
    .clk_pix(clk_pix), .reset_i(reset_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .de_i(de_i), .frame_i(frame_i), .line_i(line_i), .fmt_i(fmt_i),
    .border_rgb_i(24'h202020), .stream(if1),
    .red_o(r[1]), .green_o(g[1]), .blue_o(b[1]),
    .hsync_o(hs[1]), .vsync_o(vs[1]), .de_o(de[1]),
    .underflow_o(ufl[1]), .underflow_count_o(ucnt[1]));

  video_out_stage #(.FB_WIDTH(16), .FB_HEIGHT(10), .H_OFFSET(0), .V_OFFSET(0), .SCALE(2)) u2 (
    .clk_pix(clk_pix), .reset_i(reset_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .de_i(de_i), .frame_i(frame_i), .line_i(line_i), .fmt_i(fmt_i),
    .border_rgb_i(24'h0A0B0C), .stream(if2),
    .red_o(r[2]), .green_o(g[2]), .blue_o(b[2]),
    .hsync_o(hs[2]), .vsync_o(vs[2]), .de_o(de[2]),
    .underflow_o(ufl[2]), .underflow_count_o(ucnt[2]));

  always #5 clk_pix = ~clk_pix;

  int n_tests = 0;
  int n_fail  = 0;
  int h = 0, v = 0, f = 0;
  bit m_armed = 1'b0;
  int idx     [NI] = '{0, 0, 0};
  bit m_ufl   [NI] = '{0, 0, 0};
  int m_cnt   [NI] = '{0, 0, 0};
  int ena_cnt [NI] = '{0, 0, 0};
  bit full    [NI] = '{0, 0, 0};
  bit look_first [NI] = '{0, 0, 0};
  logic [26:0] sbq [NI][$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t frame=%0d v=%0d h=%0d: got %h, expected %h", tag, $time, f, v, h, got, exp);
    end
  endtask

  // Source word for framebuffer column sx: RGB444 ramp, or a 565 colour table in frame 2.
  function automatic logic [15:0] pval(input int fr, input int sx);
    logic [15:0] w;
    w = 16'(sx);
    if (fr == 2) begin
      case (sx % 4)
        0:       w = 16'hF800;
        1:       w = 16'h07E0;
        2:       w = 16'h001F;
        default: w = 16'hFFFF;
      endcase
    end
    return w;
  endfunction

  function automatic logic [23:0] exp_pix(input int fr, input int sx);
    logic [7:0]  x8;
    logic [23:0] c;
    x8 = 8'(sx);
    c  = {8'h00, x8[7:4], x8[7:4], x8[3:0], x8[3:0]};
    if (fr == 2) begin
      case (sx % 4)
        0:       c = 24'hFF0000;
        1:       c = 24'h00FF00;
        2:       c = 24'h0000FF;
        default: c = 24'hFFFFFF;
      endcase
    end
    return c;
  endfunction

  function automatic bit inj(input int fr, input int k);
    return (fr == 3) && (k >= 5) && (k <= 7);
  endfunction

  task automatic run_cycle(input bit rst);
    logic [26:0] exp_e;
    logic [23:0] prgb;
    int wx, wy, sx, sy;
    bit inw, e_ena;
    bit en_s [NI];
    @(negedge clk_pix);
    de_i    = (h < HA) && (v < VA);
    hsync_i = (h >= 34) && (h < 37);
    vsync_i = (v >= 21) && (v < 23);
    line_i  = (h == HT - 1);
    frame_i = (h == HT - 2) && (v == VT - 1);
    fmt_i   = (f == 2);
    reset_i = rst;
    for (int i = 0; i < NI; i++) begin
      sdat[i] = pval(f, idx[i] % FW[i]);
      serr[i] = inj(f, idx[i]);
    end
    if (rst) begin
      m_armed = 1'b0;
      for (int i = 0; i < NI; i++) begin
        m_ufl[i] = 1'b0;
        m_cnt[i] = 0;
        full[i] = 1'b0;
        look_first[i] = 1'b0;
        for (int k = 0; k < sbq[i].size(); k++) sbq[i][k] = '0;
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      if (sbq[i].size() == 2) begin
        exp_e = sbq[i].pop_front();
        check_eq($sformatf("pix%0d", i), {37'd0, r[i], g[i], b[i], hs[i], vs[i], de[i]}, {37'd0, exp_e});
      end
      check_eq($sformatf("ufl%0d", i), {47'd0, ufl[i], ucnt[i]}, {47'd0, m_ufl[i], 16'(m_cnt[i])});

      wx  = h - HO[i];
      wy  = v - VO[i];
      inw = de_i && (wx >= 0) && (wx < FW[i] * SC[i]) && (wy >= 0) && (wy < FH[i] * SC[i]);
      e_ena = m_armed && inw && (SC[i] == 1 || ((wx % 2 == 0) && (wy % 2 == 0)));
      check_eq($sformatf("ena%0d", i), {63'd0, ena[i]}, {63'd0, e_ena});
      en_s[i] = ena[i];

      sx = inw ? wx / SC[i] : 0;
      sy = inw ? wy / SC[i] : 0;
      if (rst || !de_i)             prgb = '0;
      else if (!(inw && m_armed))   prgb = BRD[i];
      else if (inj(f, sy * FW[i] + sx)) prgb = 24'hFF0000;
      else                          prgb = exp_pix(f, sx);
      sbq[i].push_back(rst ? 27'd0 : {prgb, hsync_i, vsync_i, de_i});

      if (ena[i]) begin
        ena_cnt[i]++;
        if (look_first[i]) begin
          check_eq($sformatf("first_ena%0d", i), {32'(h), 32'(v)}, {32'(HO[i]), 32'(VO[i])});
          look_first[i] = 1'b0;
        end
      end
      if (e_ena && inj(f, sy * FW[i] + sx)) begin
        m_ufl[i] = 1'b1;
        if (m_cnt[i] < 65535) m_cnt[i]++;
      end
      if (frame_i && !rst) begin
        if (full[i]) check_eq($sformatf("ena_count%0d", i), 64'(ena_cnt[i]), 64'(FW[i] * FH[i]));
        ena_cnt[i]    = 0;
        full[i]       = 1'b1;
        look_first[i] = !m_armed;
        m_ufl[i]      = 1'b0;
      end
    end
    if (frame_i && !rst) m_armed = 1'b1;

    @(posedge clk_pix);
    for (int i = 0; i < NI; i++) begin
      if (frame_i)      idx[i] = 0;
      else if (en_s[i]) idx[i]++;
    end
    h++;
    if (h == HT) begin
      h = 0;
      v++;
      if (v == VT) begin
        v = 0;
        f++;
      end
    end
  endtask

  initial begin
    int cyc;
    reset_i = 1'b1;
    hsync_i = 1'b0; vsync_i = 1'b0; de_i = 1'b0;
    frame_i = 1'b0; line_i = 1'b0; fmt_i = 1'b0;
    for (int i = 0; i < NI; i++) begin
      sdat[i] = '0;
      serr[i] = 1'b0;
    end
    cyc = 0;
    while (f < 7) begin
      run_cycle((cyc < 3) || (f == 4 && v == 7 && h >= 10 && h < 13));
      cyc++;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
